// File: rtl/ni_pkg.sv
// ni_pkg: head-flit field layout, flit width and FSM state encoding shared by
// the transmit NetworkInterface and the receive ni_depacketizer.
package ni_pkg;

  localparam int FLIT_W = 16;

  localparam int HEAD_DEST_MSB = 15;
  localparam int HEAD_DEST_LSB = 12;
  localparam int HEAD_SRC_MSB  = 11;
  localparam int HEAD_SRC_LSB  = 8;
  localparam int HEAD_LEN_MSB  = 7;
  localparam int HEAD_LEN_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2,
    DONE    = 2'd3
  } niState_e;

endpackage

// File: rtl/ni_head_decode.sv
// ni_head_decode: purely combinational split of a head flit into its
// destination, source and payload-length fields, plus a match against NODE_ID.
module ni_head_decode
  import ni_pkg::*;
#(
  parameter logic [3:0] NODE_ID = 4'h0
) (
  input  logic [FLIT_W-1:0]                      flit_i,
  output logic [HEAD_DEST_MSB-HEAD_DEST_LSB:0]   dest_o,
  output logic [HEAD_SRC_MSB-HEAD_SRC_LSB:0]     src_o,
  output logic [HEAD_LEN_MSB-HEAD_LEN_LSB:0]     len_o,
  output logic                                   destMatch_o
);

  assign dest_o      = flit_i[HEAD_DEST_MSB:HEAD_DEST_LSB];
  assign src_o       = flit_i[HEAD_SRC_MSB:HEAD_SRC_LSB];
  assign len_o       = flit_i[HEAD_LEN_MSB:HEAD_LEN_LSB];
  assign destMatch_o = (flit_i[HEAD_DEST_MSB:HEAD_DEST_LSB] == NODE_ID);

endmodule

// File: rtl/ni_depacketizer.sv
// ni_depacketizer: receive-side network interface. Consumes the flit stream
// from the router's local port, checks the head against NODE_ID, strips it and
// writes payload flits into SRAM from base_addr, then reports completion and
// length/destination errors. DATA_W stays at 16 because the head layout is 16 bits.
module ni_depacketizer
  import ni_pkg::*;
#(
  parameter logic [3:0] NODE_ID = 4'h0,
  parameter int         ADDR_W  = 8,
  parameter int         DATA_W  = FLIT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] flit_in,
  input  logic              flit_valid,
  input  logic              packet_end,
  output logic              flit_ready,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              sram_ready,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              pkt_done,
  output logic [3:0]        pkt_src,
  output logic [7:0]        pkt_len,
  output logic              err_len,
  output logic              err_dest
);

  niState_e          state_q, state_d;
  logic [3:0]        src_q, src_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              extra_q, extra_d;
  logic              sramWe_q, sramWe_d;
  logic [ADDR_W-1:0] sramAddr_q, sramAddr_d;
  logic [DATA_W-1:0] sramWdata_q, sramWdata_d;
  logic              pktDone_q, pktDone_d;
  logic [3:0]        pktSrc_q, pktSrc_d;
  logic [7:0]        pktLen_q, pktLen_d;
  logic              errLen_q, errLen_d;
  logic              errDest_q, errDest_d;

  logic              flitReady;
  logic              flitAccept;
  logic [3:0]        unusedHeadDest;
  logic [3:0]        headSrc;
  logic [7:0]        headLen;
  logic              headDestMatch;

  // Head fields are decoded from flit_in every cycle; only used when in IDLE.
  // The raw dest field is not needed here since the match flag carries it.
  ni_head_decode #(
    .NODE_ID (NODE_ID)
  ) uHeadDecode (
    .flit_i      (flit_in),
    .dest_o      (unusedHeadDest),
    .src_o       (headSrc),
    .len_o       (headLen),
    .destMatch_o (headDestMatch)
  );

  // Ready depends on state (and SRAM backpressure while writing payload);
  // held low while reset is asserted and during the one-cycle DONE bubble.
  always_comb begin
    flitReady = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE, DROP: flitReady = 1'b1;
        PAYLOAD:    flitReady = sram_ready;
        default:    flitReady = 1'b0;
      endcase
    end
  end

  assign flit_ready = flitReady;
  assign flitAccept = flit_valid && flitReady;

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    len_d       = len_q;
    wrPtr_d     = wrPtr_q;
    cnt_d       = cnt_q;
    extra_d     = extra_q;
    sramWe_d    = 1'b0;
    sramAddr_d  = sramAddr_q;
    sramWdata_d = sramWdata_q;
    pktDone_d   = 1'b0;
    pktSrc_d    = pktSrc_q;
    pktLen_d    = pktLen_q;
    errLen_d    = 1'b0;
    errDest_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (flitAccept) begin
          src_d   = headSrc;
          len_d   = headLen;
          wrPtr_d = base_addr;
          cnt_d   = 8'd0;
          extra_d = 1'b0;
          if (!headDestMatch) begin
            errDest_d = 1'b1;
          end
          if (packet_end) begin
            state_d   = DONE;
            pktDone_d = 1'b1;
            pktSrc_d  = headSrc;
            pktLen_d  = 8'd0;
            errLen_d  = headDestMatch && (headLen != 8'd0);
          end else begin
            state_d = headDestMatch ? PAYLOAD : DROP;
          end
        end
      end

      PAYLOAD: begin
        if (flitAccept) begin
          if (cnt_q < len_q) begin
            sramWe_d    = 1'b1;
            sramAddr_d  = wrPtr_q;
            sramWdata_d = flit_in;
            wrPtr_d     = wrPtr_q + ADDR_W'(1);
            cnt_d       = cnt_q + 8'd1;
          end else begin
            extra_d = 1'b1;
          end
          if (packet_end) begin
            state_d   = DONE;
            pktDone_d = 1'b1;
            pktSrc_d  = src_q;
            pktLen_d  = cnt_d;
            errLen_d  = (cnt_d != len_q) || extra_d;
          end
        end
      end

      DROP: begin
        if (flitAccept && packet_end) begin
          state_d   = DONE;
          pktDone_d = 1'b1;
          pktSrc_d  = src_q;
          pktLen_d  = 8'd0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= 4'd0;
      len_q       <= 8'd0;
      wrPtr_q     <= '0;
      cnt_q       <= 8'd0;
      extra_q     <= 1'b0;
      sramWe_q    <= 1'b0;
      sramAddr_q  <= '0;
      sramWdata_q <= '0;
      pktDone_q   <= 1'b0;
      pktSrc_q    <= 4'd0;
      pktLen_q    <= 8'd0;
      errLen_q    <= 1'b0;
      errDest_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      len_q       <= len_d;
      wrPtr_q     <= wrPtr_d;
      cnt_q       <= cnt_d;
      extra_q     <= extra_d;
      sramWe_q    <= sramWe_d;
      sramAddr_q  <= sramAddr_d;
      sramWdata_q <= sramWdata_d;
      pktDone_q   <= pktDone_d;
      pktSrc_q    <= pktSrc_d;
      pktLen_q    <= pktLen_d;
      errLen_q    <= errLen_d;
      errDest_q   <= errDest_d;
    end
  end

  assign sram_we    = sramWe_q;
  assign sram_addr  = sramAddr_q;
  assign sram_wdata = sramWdata_q;
  assign pkt_done   = pktDone_q;
  assign pkt_src    = pktSrc_q;
  assign pkt_len    = pktLen_q;
  assign err_len    = errLen_q;
  assign err_dest   = errDest_q;

endmodule

// File: tb/tb_ni_depacketizer.sv
// tb_ni_depacketizer: directed packets against ni_depacketizer (NODE_ID=1).
// Expected SRAM writes, completions and dest-error pulses are queued as each
// packet is issued; a negedge monitor pops and compares whenever the DUT
// presents one of those outputs.
module tb_ni_depacketizer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] flit_in = 16'h0;
  logic        flit_valid = 1'b0;
  logic        packet_end = 1'b0;
  logic        flit_ready;
  logic [7:0]  base_addr = 8'h0;
  logic        sram_ready = 1'b1;
  logic        sram_we;
  logic [7:0]  sram_addr;
  logic [15:0] sram_wdata;
  logic        pkt_done;
  logic [3:0]  pkt_src;
  logic [7:0]  pkt_len;
  logic        err_len;
  logic        err_dest;

  int checks = 0;
  int passes = 0;

  logic [23:0] writeQ[$];
  logic [12:0] doneQ[$];
  logic        destQ[$];

  ni_depacketizer #(
    .NODE_ID (4'h1),
    .ADDR_W  (8),
    .DATA_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flit_in    (flit_in),
    .flit_valid (flit_valid),
    .packet_end (packet_end),
    .flit_ready (flit_ready),
    .base_addr  (base_addr),
    .sram_ready (sram_ready),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .pkt_done   (pkt_done),
    .pkt_src    (pkt_src),
    .pkt_len    (pkt_len),
    .err_len    (err_len),
    .err_dest   (err_dest)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end else begin
      passes++;
    end
  endtask

  task automatic expectWrite(input logic [7:0] addr, input logic [15:0] data);
    writeQ.push_back({addr, data});
  endtask

  task automatic expectDone(input logic [3:0] src, input logic [7:0] len, input logic errLen);
    doneQ.push_back({src, len, errLen});
  endtask

  // Present one flit, optionally holding sram_ready low for 'stall' cycles
  // first; returns how many cycles the flit waited for flit_ready.
  task automatic applyStimulus(input logic [15:0] data, input logic last, input int stall, output int waited);
    int  stallLeft;
    bit  accepted;
    stallLeft = stall;
    waited    = 0;
    accepted  = 0;
    @(negedge clk);
    flit_in    = data;
    flit_valid = 1'b1;
    packet_end = last;
    while (!accepted) begin
      sram_ready = (stallLeft == 0);
      if (stallLeft > 0) stallLeft--;
      #1;
      if (flit_ready) begin
        accepted = 1;
      end else begin
        waited++;
        if (waited > 50) begin
          checks++;
          $display("[TB] FAIL acceptTimeout: flit %h not accepted after %0d cycles, expected acceptance", data, waited);
          break;
        end
        @(negedge clk);
      end
    end
    if (accepted) @(posedge clk);
    #1;
    flit_valid = 1'b0;
    packet_end = 1'b0;
    flit_in    = 16'h0;
  endtask

  task automatic sendFlit(input logic [15:0] data, input logic last);
    int w;
    applyStimulus(data, last, 0, w);
  endtask

  task automatic idleCycles(input int n, input logic pe);
    @(negedge clk);
    flit_valid = 1'b0;
    packet_end = pe;
    repeat (n) @(posedge clk);
    #1;
    packet_end = 1'b0;
  endtask

  // Scoreboard monitor: compares every presented write, completion and error pulse.
  initial begin
    logic [23:0] expW;
    logic [12:0] expD;
    logic        expE;
    forever begin
      @(negedge clk);
      if (sram_we === 1'b1) begin
        if (writeQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpectedWrite: addr=%h data=%h, expected no write", sram_addr, sram_wdata);
        end else begin
          expW = writeQ.pop_front();
          checkOutput("sramWrite", {8'h0, sram_addr, sram_wdata}, {8'h0, expW});
        end
      end
      if (pkt_done === 1'b1) begin
        if (doneQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpectedDone: src=%h len=%0d errLen=%b, expected no pkt_done", pkt_src, pkt_len, err_len);
        end else begin
          expD = doneQ.pop_front();
          checkOutput("pktDone{src,len,errLen}", {19'h0, pkt_src, pkt_len, err_len}, {19'h0, expD});
        end
      end
      if (err_len === 1'b1 && pkt_done !== 1'b1) begin
        checks++;
        $display("[TB] FAIL errLenAlone: err_len=1 pkt_done=%b, expected err_len only with pkt_done", pkt_done);
      end
      if (err_dest === 1'b1) begin
        if (destQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpectedErrDest: err_dest=1, expected 0");
        end else begin
          expE = destQ.pop_front();
          checkOutput("errDest", {31'h0, err_dest}, {31'h0, expE});
        end
      end
    end
  end

  initial begin
    int waited;

    $display("[TB] reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstFlitReady", {31'h0, flit_ready}, 32'h0);
    checkOutput("rstSramWe", {31'h0, sram_we}, 32'h0);
    checkOutput("rstSramAddr", {24'h0, sram_addr}, 32'h0);
    checkOutput("rstSramWdata", {16'h0, sram_wdata}, 32'h0);
    checkOutput("rstPktDone", {31'h0, pkt_done}, 32'h0);
    checkOutput("rstPktSrc", {28'h0, pkt_src}, 32'h0);
    checkOutput("rstPktLen", {24'h0, pkt_len}, 32'h0);
    checkOutput("rstErrLen", {31'h0, err_len}, 32'h0);
    checkOutput("rstErrDest", {31'h0, err_dest}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("idleFlitReady", {31'h0, flit_ready}, 32'h1);

    $display("[TB] basic packet, packet_end without valid ignored");
    base_addr = 8'h10;
    expectWrite(8'h10, 16'hA5A5);
    expectWrite(8'h11, 16'h5A5A);
    expectWrite(8'h12, 16'h1234);
    expectDone(4'h2, 8'd3, 1'b0);
    sendFlit(16'h1203, 1'b0);
    sendFlit(16'hA5A5, 1'b0);
    idleCycles(2, 1'b1);
    sendFlit(16'h5A5A, 1'b0);
    sendFlit(16'h1234, 1'b1);
    checkOutput("doneBubbleReady", {31'h0, flit_ready}, 32'h0);

    $display("[TB] wrong destination dropped");
    destQ.push_back(1'b1);
    expectDone(4'h2, 8'd0, 1'b0);
    sendFlit(16'h3203, 1'b0);
    sendFlit(16'h1111, 1'b0);
    sendFlit(16'h2222, 1'b0);
    sendFlit(16'h3333, 1'b1);

    $display("[TB] early tail");
    base_addr = 8'h20;
    expectWrite(8'h20, 16'h0F0F);
    expectWrite(8'h21, 16'hFFFF);
    expectDone(4'h2, 8'd2, 1'b1);
    sendFlit(16'h1205, 1'b0);
    sendFlit(16'h0F0F, 1'b0);
    sendFlit(16'hFFFF, 1'b1);

    $display("[TB] address wrap");
    base_addr = 8'hFE;
    expectWrite(8'hFE, 16'h0001);
    expectWrite(8'hFF, 16'h0002);
    expectWrite(8'h00, 16'h0003);
    expectWrite(8'h01, 16'h0004);
    expectDone(4'h4, 8'd4, 1'b0);
    sendFlit(16'h1404, 1'b0);
    sendFlit(16'h0001, 1'b0);
    sendFlit(16'h0002, 1'b0);
    sendFlit(16'h0003, 1'b0);
    sendFlit(16'h0004, 1'b1);

    $display("[TB] sram backpressure");
    base_addr = 8'h30;
    expectWrite(8'h30, 16'hAAAA);
    expectWrite(8'h31, 16'hBBBB);
    expectWrite(8'h32, 16'hCCCC);
    expectDone(4'h3, 8'd3, 1'b0);
    sendFlit(16'h1303, 1'b0);
    sendFlit(16'hAAAA, 1'b0);
    applyStimulus(16'hBBBB, 1'b0, 3, waited);
    checkOutput("stallCycles", waited, 32'd3);
    sendFlit(16'hCCCC, 1'b1);

    $display("[TB] zero length, tail on head");
    expectDone(4'h5, 8'd0, 1'b0);
    sendFlit(16'h1500, 1'b1);

    $display("[TB] zero length with extra flit");
    expectDone(4'h6, 8'd0, 1'b1);
    sendFlit(16'h1600, 1'b0);
    sendFlit(16'hDEAD, 1'b1);

    $display("[TB] wrong destination, tail on head");
    destQ.push_back(1'b1);
    expectDone(4'h7, 8'd0, 1'b0);
    sendFlit(16'h2700, 1'b1);

    $display("[TB] reset mid-packet");
    base_addr = 8'h40;
    expectWrite(8'h40, 16'h9999);
    sendFlit(16'h1203, 1'b0);
    sendFlit(16'h9999, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midRstFlitReady", {31'h0, flit_ready}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midRstPktSrc", {28'h0, pkt_src}, 32'h0);
    checkOutput("midRstSramAddr", {24'h0, sram_addr}, 32'h0);
    reset = 1'b1;
    base_addr = 8'h50;
    expectWrite(8'h50, 16'h8765);
    expectDone(4'h1, 8'd1, 1'b0);
    sendFlit(16'h1101, 1'b0);
    sendFlit(16'h8765, 1'b1);

    repeat (4) @(negedge clk);
    #1;
    checkOutput("writesPending", writeQ.size(), 32'd0);
    checkOutput("donesPending", doneQ.size(), 32'd0);
    checkOutput("errDestPending", destQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ni_depacketizer.md
Name: ni_depacketizer

Overview:
Receive-side network interface; the counterpart of the transmit NetworkInterface that turns SRAM words into 16-bit flits.
- Accepts the flit stream (data, packet_end, valid/ready) from the router's local port.
- Checks the head flit against this node's ID.
- Strips the header and writes payload flits into local SRAM from a programmable base address.
- Reports per-packet completion and length/destination errors.

Parameters:
NODE_ID, 4'h0, this node's address; compared with head flit dest field
ADDR_W, 8, SRAM address width; write address wraps modulo 2^ADDR_W
DATA_W, 16, flit and SRAM word width (fixed at 16 by header format)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
flit_in  in  16  incoming flit
flit_valid  in  1  flit_in valid
packet_end  in  1  qualifies flit_in as the tail flit
flit_ready  out  1  block can accept a flit this cycle
base_addr  in  ADDR_W  SRAM start address, sampled when the head flit is accepted
sram_ready  in  1  SRAM can take a write this cycle
sram_we  out  1  SRAM write strobe
sram_addr  out  ADDR_W  SRAM write address
sram_wdata  out  16  SRAM write data
pkt_done  out  1  one-cycle pulse: packet fully received and written
pkt_src  out  4  source ID of the last completed/dropped packet
pkt_len  out  8  payload flits actually written for the last packet
err_len  out  1  one-cycle pulse with pkt_done: payload count != header length
err_dest  out  1  one-cycle pulse: packet dropped, dest != NODE_ID

Behaviour:
- Handshake: a flit is accepted on a rising edge where flit_valid && flit_ready.
- Head flit format: [15:12] dest, [11:8] src, [7:0] len (payload flit count, 0..255).
- Reset (reset==0 at clk edge):
  - state=IDLE; flit_ready=0 during reset.
  - sram_we=0, sram_addr=0, sram_wdata=0.
  - pkt_done=0, err_len=0, err_dest=0, pkt_src=0, pkt_len=0.
  - Reset mid-packet aborts the packet. No further writes; no done or error pulse.
- States: IDLE, PAYLOAD, DROP, DONE.
- IDLE:
  - flit_ready=1.
  - Accepted flit is the head. Latch src, len, and wr_ptr<=base_addr; clear cnt.
  - dest==NODE_ID: if packet_end is set on the head, go to DONE; otherwise go to PAYLOAD.
  - dest!=NODE_ID: pulse err_dest next cycle. If packet_end is set on the head, go to DONE (drop); otherwise go to DROP.
- PAYLOAD:
  - flit_ready = sram_ready.
  - Each accepted flit with cnt<len: next cycle sram_we=1, sram_addr=wr_ptr, sram_wdata=flit. Then wr_ptr++ (wraps), cnt++.
  - Flits accepted with cnt>=len are consumed and not written.
  - Tail accepted: go to DONE.
- DROP:
  - flit_ready=1; flits consumed, never written.
  - Tail: go to DONE with pkt_len=0 and no err_len.
- DONE (exactly one cycle):
  - flit_ready=0 (one-cycle bubble).
  - pkt_done=1; pkt_src/pkt_len updated. pkt_done also pulses for dropped packets.
  - err_len=1 if the packet was accepted and (cnt!=len, or extra flits were received).
  - Next state is IDLE.
- Latency:
  - Payload flit accepted in cycle N produces its SRAM write in N+1.
  - Tail accepted in cycle N: its write (if any) and pkt_done both occur in N+1.
- Outputs registered; sram_we is low in every cycle without a new write.
- Boundary cases:
  - len=0 with tail on head: pkt_done and no write; err_len=0.
  - len=0 followed by extra flits: the flits are discarded and err_len=1.
  - Early tail (cnt<len): written flits are kept, pkt_len=cnt, err_len=1.
  - Address wrap: 2^ADDR_W-1 -> 0 with no error.
  - flit_valid while sram_ready=0 in PAYLOAD: flit held upstream, no loss.
  - packet_end with flit_valid=0 is ignored.

Decomposition:
- Shared package ni_pkg holds:
  - Field positions HEAD_DEST_MSB/LSB, HEAD_SRC_MSB/LSB, HEAD_LEN_MSB/LSB.
  - The flit width constant.
  - The state encoding (IDLE/PAYLOAD/DROP/DONE).
  The transmit NetworkInterface uses the same package.
- One sub-module is natural: ni_head_decode. It is combinational and produces dest, src, len and dest_match from flit_in.

Test Plan:
- Head 16'h1203 (dest1, src2, len3) with NODE_ID=1, base 8'h10. Payload A5A5, 5A5A, 1234, tail on 1234 -> writes 10:A5A5, 11:5A5A, 12:1234. pkt_done pulses with pkt_src=2, pkt_len=3, err_len=0.
- Head 16'h3203 with NODE_ID=1, then 3 flits with tail -> no sram_we; err_dest pulse; pkt_done with pkt_len=0.
- Head 16'h1205, tail on the 2nd payload (FFFF) -> 2 writes, pkt_len=2, err_len=1.
- Base 8'hFE, len 4 -> writes to FE, FF, 00, 01. err_len=0.
- sram_ready low for 3 cycles mid-payload -> flit_ready=0 for those cycles; no flits lost or duplicated; data order preserved.
- Drive reset=0 after 1 of 3 payload flits -> no pkt_done. A following head 16'h1101 with one tail flit 8765 -> written at base_addr; pkt_done with pkt_len=1.
